// File: rtl/eth_txbytefeed_if.sv
// Host/MAC-side signal bundle for the transmit byte feeder.
// master: host + MAC control stage, slave: the feeder itself.
interface eth_txbytefeed_if #(
  parameter int unsigned AW = 4
);
  // Host write side
  logic        WrEn;
  logic [31:0] WrData;
  logic        FifoFull;
  logic [AW:0] FifoCnt;
  // Frame control and completion status
  logic        StartReq;
  logic [15:0] FrameLen;
  logic        Busy;
  logic        FrameDone;
  logic [1:0]  FrameStatus;
  // Byte stream towards the MAC control stage
  logic [7:0]  TxData;
  logic        TxStartFrm;
  logic        TxEndFrm;
  logic        TxUsedData;
  logic        TxDone;
  logic        TxAbort;
  logic        TxUnderRun;

  modport master (
    output WrEn, WrData, StartReq, FrameLen, TxUsedData, TxDone, TxAbort,
    input  FifoFull, FifoCnt, Busy, FrameDone, FrameStatus,
    input  TxData, TxStartFrm, TxEndFrm, TxUnderRun
  );

  modport slave (
    input  WrEn, WrData, StartReq, FrameLen, TxUsedData, TxDone, TxAbort,
    output FifoFull, FifoCnt, Busy, FrameDone, FrameStatus,
    output TxData, TxStartFrm, TxEndFrm, TxUnderRun
  );
endinterface

// File: rtl/eth_txbytefeed.sv
// Transmit byte feeder: buffers 32-bit host words in a FWFT FIFO and serialises
// one frame at a time into the MAC byte stream, reporting a per-frame status.
module eth_txbytefeed #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input logic              MTxClk,
  input logic              TxResetn,
  eth_txbytefeed_if.slave  bus
);

  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StWaitD, StSend, StWaitS, StDrain} stateT;

  // FIFO storage and bookkeeping
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   fifoCnt;
  logic          fifoEmpty, fifoFull, push, pop;
  logic [31:0]   head;

  // Frame state
  stateT       state;
  logic [31:0] wordReg;
  logic [1:0]  byteIdx;
  logic [15:0] byteCnt;
  logic [14:0] wordsLeft;
  logic [14:0] lenWords;
  logic [1:0]  status;
  logic [7:0]  txData;
  logic        txStartFrm, txEndFrm, txUnderRun, frameDone;
  logic [1:0]  frameStatus;
  logic        popWaitD, popSend, popDrain;

  function automatic logic [7:0] pickByte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    pickByte = w[31:24];
      2'd1:    pickByte = w[23:16];
      2'd2:    pickByte = w[15:8];
      default: pickByte = w[7:0];
    endcase
  endfunction

  // FIFO status, head word and pop requests from the frame FSM
  always_comb begin
    fifoEmpty = (fifoCnt == '0);
    fifoFull  = (fifoCnt == FullCnt);
    push      = bus.WrEn && !fifoFull;
    head      = mem[rdPtr];
    lenWords  = {1'b0, bus.FrameLen[15:2]} + 15'(|bus.FrameLen[1:0]);
    popWaitD  = (state == StWaitD) && !bus.TxAbort && !fifoEmpty;
    // Refill as the last byte of a word is consumed so the next byte is ready next clock
    popSend   = (state == StSend) && !bus.TxAbort && bus.TxUsedData && (byteIdx == 2'd3) &&
                (byteCnt > 16'd1) && !fifoEmpty;
    popDrain  = (state == StDrain) && (wordsLeft != '0) && !fifoEmpty;
    pop       = popWaitD || popSend || popDrain;
  end

  // FIFO storage write (no reset needed; validity tracked by fifoCnt)
  always_ff @(posedge MTxClk) begin
    if (push) mem[wrPtr] <= bus.WrData;
  end

  // FIFO pointers and word count
  always_ff @(posedge MTxClk or negedge TxResetn) begin
    if (!TxResetn) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      fifoCnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      fifoCnt <= fifoCnt + 1'b1;
      else if (!push && pop) fifoCnt <= fifoCnt - 1'b1;
    end
  end

  // Frame FSM with registered byte-stream and status outputs
  always_ff @(posedge MTxClk or negedge TxResetn) begin
    if (!TxResetn) begin
      state       <= StIdle;
      wordReg     <= '0;
      byteIdx     <= '0;
      byteCnt     <= '0;
      wordsLeft   <= '0;
      status      <= 2'b00;
      txData      <= '0;
      txStartFrm  <= 1'b0;
      txEndFrm    <= 1'b0;
      txUnderRun  <= 1'b0;
      frameDone   <= 1'b0;
      frameStatus <= 2'b00;
    end else begin
      frameDone <= 1'b0;
      case (state)
        StIdle: begin
          if (bus.StartReq && (bus.FrameLen != 16'd0)) begin
            byteCnt   <= bus.FrameLen;
            wordsLeft <= lenWords;
            state     <= StWaitD;
          end
        end
        StWaitD: begin
          if (bus.TxAbort) begin
            status <= 2'b01;
            state  <= StDrain;
          end else if (!fifoEmpty) begin
            wordReg    <= head;
            byteIdx    <= 2'd0;
            wordsLeft  <= wordsLeft - 15'd1;
            txData     <= head[31:24];
            txStartFrm <= 1'b1;
            txEndFrm   <= (byteCnt == 16'd1);
            state      <= StSend;
          end
        end
        StSend: begin
          if (bus.TxAbort) begin
            status     <= 2'b01;
            txStartFrm <= 1'b0;
            txEndFrm   <= 1'b0;
            state      <= StDrain;
          end else if (bus.TxUsedData) begin
            txStartFrm <= 1'b0;
            if (txEndFrm) begin
              txEndFrm <= 1'b0;
              state    <= StWaitS;
            end else if (byteIdx == 2'd3) begin
              byteCnt <= byteCnt - 16'd1;
              if (fifoEmpty) begin
                txUnderRun <= 1'b1;
                status     <= 2'b10;
                state      <= StDrain;
              end else begin
                wordReg   <= head;
                byteIdx   <= 2'd0;
                wordsLeft <= wordsLeft - 15'd1;
                txData    <= head[31:24];
                txEndFrm  <= (byteCnt == 16'd2);
              end
            end else begin
              byteIdx  <= byteIdx + 2'd1;
              byteCnt  <= byteCnt - 16'd1;
              txData   <= pickByte(wordReg, byteIdx + 2'd1);
              txEndFrm <= (byteCnt == 16'd2);
            end
          end
        end
        StWaitS: begin
          // Abort takes priority over a simultaneous done
          if (bus.TxAbort) begin
            status <= 2'b01;
            state  <= StDrain;
          end else if (bus.TxDone) begin
            status <= 2'b00;
            state  <= StDrain;
          end
        end
        StDrain: begin
          if (txUnderRun && (bus.TxDone || bus.TxAbort)) txUnderRun <= 1'b0;
          if (popDrain) wordsLeft <= wordsLeft - 15'd1;
          if ((wordsLeft == '0) && !txUnderRun) begin
            frameDone   <= 1'b1;
            frameStatus <= status;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.FifoFull    = fifoFull;
  assign bus.FifoCnt     = fifoCnt;
  assign bus.Busy        = (state != StIdle);
  assign bus.TxData      = txData;
  assign bus.TxStartFrm  = txStartFrm;
  assign bus.TxEndFrm    = txEndFrm;
  assign bus.TxUnderRun  = txUnderRun;
  assign bus.FrameDone   = frameDone;
  assign bus.FrameStatus = frameStatus;

endmodule

// File: doc/eth_txbytefeed.md
Name: eth_txbytefeed

Overview:
Host-side transmit byte feeder in the MTxClk domain. It buffers 32-bit host words in an internal first-word-fall-through FIFO. It then serialises one frame at a time into the byte stream that the MAC control stage consumes: data byte, start-of-frame, end-of-frame, advanced by the used-data strobe. It also collects done, abort and underrun completion into a per-frame status pulse for the host.

Parameters:
FIFO_DEPTH, 16, number of 32-bit words in the internal FIFO; power of two, minimum 4.
AW, 4, log2(FIFO_DEPTH).

Ports:
MTxClk  in  1  transmit clock.
TxResetn  in  1  reset.
WrEn  in  1  host write strobe; ignored when FifoFull=1.
WrData  in  32  host word; byte order is [31:24] first, then [23:16], [15:8], [7:0].
FifoFull  out  1  FIFO holds FIFO_DEPTH words.
FifoCnt  out  AW+1  current FIFO word count.
StartReq  in  1  single-cycle request to send one frame.
FrameLen  in  16  frame length in bytes; sampled when StartReq=1.
Busy  out  1  frame in progress (any state other than IDLE).
TxData  out  8  current byte presented downstream.
TxStartFrm  out  1  first byte of the frame is being presented.
TxEndFrm  out  1  last byte of the frame is being presented.
TxUsedData  in  1  downstream consumed the current byte.
TxDone  in  1  downstream completed the frame.
TxAbort  in  1  downstream aborted the frame.
TxUnderRun  out  1  feeder ran out of data mid-frame.
FrameDone  out  1  single-cycle pulse at frame completion.
FrameStatus  out  2  valid when FrameDone=1: 00 ok, 01 abort, 10 underrun.

Behaviour:
- Reset: TxResetn is asynchronous, active-low; clock is MTxClk.
  - FIFO emptied, FifoCnt=0, FifoFull=0.
  - State=IDLE; Busy, TxStartFrm, TxEndFrm, TxUnderRun, FrameDone all 0.
  - TxData=0, FrameStatus=00.
  - Reset mid-frame abandons the frame with no FrameDone pulse.
- FIFO:
  - A write accepted at clock k is visible at the read side at k+1.
  - Simultaneous push and pop leaves FifoCnt unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame counters, loaded on StartReq in IDLE:
  - ByteCnt = FrameLen.
  - WordsLeft = ceil(FrameLen/4).
- StartReq handling:
  - Ignored when Busy=1.
  - Ignored when FrameLen=0; no FrameDone is generated.
- IDLE -> WAITD on an accepted StartReq.
- WAITD -> SEND once FIFO is not empty:
  - Pop the head word into WordReg.
  - Set ByteIdx=0 and decrement WordsLeft.
- SEND:
  - TxData = WordReg byte selected by ByteIdx.
  - TxStartFrm=1 from entry until the first TxUsedData.
  - TxEndFrm=1 while ByteCnt=1; with FrameLen=1, TxStartFrm and TxEndFrm are high together.
  - On each TxUsedData: ByteCnt-1 and ByteIdx+1.
  - When ByteIdx=3 and ByteCnt>1, pop the next word in the same cycle so the new byte is valid on the next clock.
  - Unused trailing bytes of the last word are discarded.
- Underrun: TxUsedData with ByteIdx=3, ByteCnt>1 and FIFO empty:
  - TxUnderRun goes high on the next clock and stays high until TxDone or TxAbort.
  - State -> DRAIN, Status=underrun.
- End of data: TxUsedData with TxEndFrm=1 moves SEND -> WAITS; TxStartFrm and TxEndFrm go low.
- WAITS:
  - TxDone -> Status=ok.
  - TxAbort -> Status=abort.
  - If both are high in the same cycle, abort wins.
  - Either way -> DRAIN.
- TxAbort in WAITD or SEND -> DRAIN with Status=abort, even before the end byte.
- DRAIN:
  - Pop and discard words while WordsLeft>0, one per cycle, waiting for host writes as needed.
  - When WordsLeft=0 and TxUnderRun is clear: FrameDone=1 for one cycle with FrameStatus, then IDLE.
  - In the underrun case, the state waits for TxDone or TxAbort before finishing; the underrun status is kept.
- FrameStatus holds its last value until the next FrameDone.
- No retry: a retransmission is a new StartReq with the data rewritten.

Test Plan:
- Write 0x01020304 and 0x05060708, StartReq with FrameLen=6, one TxUsedData per cycle -> TxData sequence 01,02,03,04,05,06; TxStartFrm only with 01; TxEndFrm only with 06; FIFO empty afterwards; TxDone -> FrameDone with FrameStatus=00.
- FrameLen=1, word 0xAABBCCDD -> TxData=AA with TxStartFrm=TxEndFrm=1; after TxUsedData and TxDone, FrameStatus=00 and FifoCnt=0.
- FrameLen=12 with only one word written -> after the 4th TxUsedData, TxUnderRun=1; write 2 words then TxAbort -> both words drained, FrameStatus=10.
- FrameLen=8, TxAbort after 2 bytes, second word arriving later -> both words consumed, FrameDone with FrameStatus=01, Busy=0.
- Fill FIFO with 16 words -> FifoFull=1 and a 17th WrEn is ignored; StartReq while Busy and StartReq with FrameLen=0 -> both ignored; assert TxResetn low mid-SEND -> all outputs return to 0 and no FrameDone is seen.
